// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the round-robin fixed-to-float converter.
// Optional feature macro: FPCVT_ARB_SAT_CNT_EN (saturation event counter).
package fpcvt_pkg;

    localparam int D_W     = 12;
    localparam int E_W     = 3;
    localparam int F_W     = 4;
    localparam int SAT_MAG = 1984;

    typedef struct packed {
        logic           s;
        logic [E_W-1:0] e;
        logic [F_W-1:0] f;
    } fp_res_t;

endpackage

// File: rtl/fpcvt_core.sv
// Combinational 12-bit two's complement to sign / 3-bit exponent / 4-bit
// fraction converter (value = F * 2^E), round-half-up on the first dropped
// bit, clamping to the largest code when the exponent runs past 7.
module fpcvt_core
    import fpcvt_pkg::*;
(
    input  logic [D_W-1:0] i_d,
    output fp_res_t        o_res,
    output logic           o_sat
);

    logic [D_W-1:0] w_mag;
    logic [3:0]     w_pos;
    logic [3:0]     w_exp_raw;
    logic [F_W-1:0] w_frac_raw;
    logic           w_rnd;
    logic [F_W:0]   w_frac_rnd;
    logic [3:0]     w_exp_adj;
    logic [F_W-1:0] w_frac_adj;

    // -2048 negates to 12'h800, which reads correctly as an unsigned 2048.
    assign w_mag = i_d[D_W-1] ? (~i_d + 1'b1) : i_d;

    // Position of the leading one (0 for a zero magnitude).
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < D_W; i++) begin
            if (w_mag[i]) w_pos = 4'(i);
        end
    end

    // Small magnitudes (leading one at bit 3 or below) use E = 0 and no rounding.
    assign w_exp_raw  = (w_pos > 4'd3) ? (w_pos - 4'd3) : 4'd0;
    assign w_frac_raw = F_W'(w_mag >> w_exp_raw);
    assign w_rnd      = 1'({w_mag, 1'b0} >> w_exp_raw);
    assign w_frac_rnd = {1'b0, w_frac_raw} + {{F_W{1'b0}}, w_rnd};

    // Renormalise on fraction overflow, then clamp exponent overflow.
    always_comb begin
        w_exp_adj  = w_exp_raw;
        w_frac_adj = w_frac_rnd[F_W-1:0];
        if (w_frac_rnd[F_W]) begin
            w_frac_adj = 4'b1000;
            w_exp_adj  = w_exp_raw + 4'd1;
        end
        if (w_exp_adj > 4'd7) begin
            w_exp_adj  = 4'd7;
            w_frac_adj = 4'b1111;
        end
    end

    assign o_res.s = i_d[D_W-1];
    assign o_res.e = w_exp_adj[E_W-1:0];
    assign o_res.f = w_frac_adj;
    assign o_sat   = (w_mag >= D_W'(SAT_MAG));

endmodule

// File: rtl/fpcvt_arbiter.sv
// Round-robin scheduler sharing one fpcvt_core among N_REQ requesters:
// arbitrate -> stage-1 sample register -> convert -> buffered output port.
// Optional feature macro: FPCVT_ARB_SAT_CNT_EN adds the sat_cnt port.
module fpcvt_arbiter
    import fpcvt_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [D_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_id,
    output logic                 out_s,
    output logic [E_W-1:0]       out_e,
    output logic [F_W-1:0]       out_f
`ifdef FPCVT_ARB_SAT_CNT_EN
    ,
    output logic [7:0]           sat_cnt
`endif
);

    logic [ID_W-1:0] r_rr;
    logic            r_vld_p1;
    logic [D_W-1:0]  r_d_p1;
    logic [ID_W-1:0] r_id_p1;

    logic            w_any;
    logic [ID_W-1:0] w_gnt_idx;
    logic            w_out_load;
    logic            w_can_load;
    logic            w_accept;
    fp_res_t         w_res;
    logic            w_sat;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_rr) + k) % N_REQ]) begin
                w_any     = 1'b1;
                w_gnt_idx = ID_W'((int'(r_rr) + k) % N_REQ);
            end
        end
    end

    assign w_out_load = r_vld_p1 && (!out_valid || out_ready);
    assign w_can_load = !r_vld_p1 || w_out_load;
    assign w_accept   = w_any && w_can_load && rst_n;

    // One-hot ready to the granted requester, only when stage 1 can take it.
    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_gnt_idx] = 1'b1;
    end

    // Round-robin pointer and stage-1 valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr     <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_can_load) r_vld_p1 <= w_accept;
        end
    end

    // Stage-1 sample and source ID; meaningful only while r_vld_p1 is set.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_d_p1  <= req_data[int'(w_gnt_idx)*D_W +: D_W];
            r_id_p1 <= w_gnt_idx;
        end
    end

    fpcvt_core u_core (
        .i_d   (r_d_p1),
        .o_res (w_res),
        .o_sat (w_sat)
    );

    // Output register: load from stage 1, clear when drained with nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_s     <= 1'b0;
            out_e     <= '0;
            out_f     <= '0;
        end else if (w_out_load) begin
            out_valid <= 1'b1;
            out_id    <= r_id_p1;
            out_s     <= w_res.s;
            out_e     <= w_res.e;
            out_f     <= w_res.f;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FPCVT_ARB_SAT_CNT_EN
    // Count saturating samples as they enter the output register; sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (w_out_load && w_sat && (sat_cnt != 8'hFF)) begin
            sat_cnt <= sat_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Self-checking bench for fpcvt_arbiter: vector table, scoreboard and
// hand-written multi-cycle sequences (latency, fairness, backpressure, reset).
module tb_fpcvt_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [12*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [IDW-1:0]  out_id;
    logic            out_s;
    logic [2:0]      out_e;
    logic [3:0]      out_f;
`ifdef FPCVT_ARB_SAT_CNT_EN
    logic [7:0]      sat_cnt;
`endif

    fpcvt_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_s     (out_s),
        .out_e     (out_e),
        .out_f     (out_f)
`ifdef FPCVT_ARB_SAT_CNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           s;
        logic [2:0]     e;
        logic [3:0]     f;
        logic           sat;
    } exp_t;

    typedef struct {
        logic [11:0] d;
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic        sat;
    } vec_t;

    exp_t sb[$];
    vec_t tab[12];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tb_rr   = 0;
    int   exp_sat = 0;
    logic use_tab = 1'b0;
    exp_t tab_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference conversion by rounding-add on the integer magnitude.
    function automatic exp_t model(input int id, input logic [11:0] d);
        exp_t r;
        int   v, m, e, f;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        if (m < 16) begin
            e = 0;
            f = m;
        end else begin
            e = 0;
            while ((m >> e) > 15) e++;
            f = (m + (1 << (e - 1))) >> e;
            if (f == 16) begin
                f = 8;
                e++;
            end
        end
        if (e > 7) begin
            e = 7;
            f = 15;
        end
        r.id  = IDW'(id);
        r.s   = d[11];
        r.e   = 3'(e);
        r.f   = 4'(f);
        r.sat = (m >= 1984);
        return r;
    endfunction

    // One clock: record accepts into the scoreboard, check drained outputs.
    task automatic cycle(output logic [N-1:0] acc);
        exp_t x;
        int   idx;
        #1;
        acc = req_valid & req_ready;
        if (acc != '0) begin
            idx = -1;
            for (int k = 0; k < N; k++) begin
                if (idx < 0 && req_valid[(tb_rr + k) % N]) idx = (tb_rr + k) % N;
            end
            chk("grant", 32'(acc), 32'(1 << idx));
            if (use_tab) begin
                x    = tab_exp;
                x.id = IDW'(idx);
            end else begin
                x = model(idx, req_data[12*idx +: 12]);
            end
            sb.push_back(x);
            tb_rr = (idx + 1) % N;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'(0));
            end else begin
                x = sb.pop_front();
                chk("out_id", 32'(out_id), 32'(x.id));
                chk("out_s",  32'(out_s),  32'(x.s));
                chk("out_e",  32'(out_e),  32'(x.e));
                chk("out_f",  32'(out_f),  32'(x.f));
                if (x.sat && exp_sat < 255) exp_sat++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic [N-1:0] a;
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) cycle(a);
        chk("drain_empty", 32'(sb.size()), 32'(0));
        #1;
        chk("drain_idle", 32'(out_valid), 32'(0));
`ifdef FPCVT_ARB_SAT_CNT_EN
        chk("sat_cnt", 32'(sat_cnt), 32'(exp_sat));
`endif
    endtask

    initial begin
        logic [N-1:0] acc;
        logic [IDW-1:0] snap_id;
        logic snap_s;
        logic [2:0] snap_e;
        logic [3:0] snap_f;

        tab[0]  = '{12'hE80, 1'b1, 3'd5, 4'b1100, 1'b0};
        tab[1]  = '{12'h680, 1'b0, 3'd7, 4'b1101, 1'b0};
        tab[2]  = '{12'h6C0, 1'b0, 3'd7, 4'b1110, 1'b0};
        tab[3]  = '{12'h07C, 1'b0, 3'd4, 4'b1000, 1'b0};
        tab[4]  = '{12'h002, 1'b0, 3'd0, 4'b0010, 1'b0};
        tab[5]  = '{12'h800, 1'b1, 3'd7, 4'b1111, 1'b1};
        tab[6]  = '{12'h7FF, 1'b0, 3'd7, 4'b1111, 1'b1};
        tab[7]  = '{12'h7BF, 1'b0, 3'd7, 4'b1111, 1'b0};
        tab[8]  = '{12'h000, 1'b0, 3'd0, 4'b0000, 1'b0};
        tab[9]  = '{12'hFFF, 1'b1, 3'd0, 4'b0001, 1'b0};
        tab[10] = '{12'h008, 1'b0, 3'd0, 4'b1000, 1'b0};
        tab[11] = '{12'h010, 1'b0, 3'd1, 4'b1000, 1'b0};

        // Reset state
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_id",    32'(out_id),    32'(0));
        chk("rst_out_sef",   32'({out_s, out_e, out_f}), 32'(0));
`ifdef FPCVT_ARB_SAT_CNT_EN
        chk("rst_sat_cnt",   32'(sat_cnt),   32'(0));
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);

        // Latency: accepted at edge k, out_valid after edge k+1
        out_ready       = 1'b1;
        req_valid       = 4'b0001;
        req_data[11:0]  = 12'hE80;
        cycle(acc);
        chk("lat_acc", 32'(acc), 32'(1));
        req_valid = '0;
        #1;
        chk("lat_k", 32'(out_valid), 32'(0));
        cycle(acc);
        #1;
        chk("lat_k1", 32'(out_valid), 32'(1));
        chk("lat_id", 32'(out_id), 32'(0));
        drain();

        // Vector table through requester 0, back to back
        use_tab   = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            req_data[11:0] = tab[i].d;
            tab_exp.id  = '0;
            tab_exp.s   = tab[i].s;
            tab_exp.e   = tab[i].e;
            tab_exp.f   = tab[i].f;
            tab_exp.sat = tab[i].sat;
            cycle(acc);
            chk("single_grant", 32'(acc), 32'(1));
        end
        use_tab = 1'b0;
        drain();

        // Saturation counter clamps at 255
        req_valid      = 4'b0001;
        req_data[11:0] = 12'h7FF;
        for (int i = 0; i < 300; i++) cycle(acc);
        drain();
`ifdef FPCVT_ARB_SAT_CNT_EN
        chk("sat_clamp", 32'(sat_cnt), 32'(255));
`endif

        // Fairness: all valid, one result per cycle
        for (int j = 0; j < N; j++) req_data[12*j +: 12] = 12'($urandom);
        req_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i >= 2) begin
                #1;
                chk("throughput", 32'(out_valid), 32'(1));
            end
            cycle(acc);
            chk("fair_acc", 32'(acc != '0), 32'(1));
            for (int j = 0; j < N; j++) if (acc[j]) req_data[12*j +: 12] = 12'($urandom);
        end
        drain();

        // Backpressure: fill s1 and output, stall 5 cycles, release
        req_valid = '1;
        out_ready = 1'b0;
        cycle(acc);
        cycle(acc);
        #1;
        snap_id = out_id;
        snap_s  = out_s;
        snap_e  = out_e;
        snap_f  = out_f;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'(0));
            chk("stall_valid", 32'(out_valid), 32'(1));
            chk("stall_hold",  32'({out_id, out_s, out_e, out_f}),
                               32'({snap_id, snap_s, snap_e, snap_f}));
            cycle(acc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(acc);
            for (int j = 0; j < N; j++) if (acc[j]) req_data[12*j +: 12] = 12'($urandom);
        end
        drain();

        // Reset mid-stream with s1 and output both full
        req_valid = '1;
        out_ready = 1'b0;
        cycle(acc);
        cycle(acc);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_ready", 32'(req_ready), 32'(0));
`ifdef FPCVT_ARB_SAT_CNT_EN
        chk("mid_rst_sat",   32'(sat_cnt),   32'(0));
`endif
        sb.delete();
        tb_rr   = 0;
        exp_sat = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle(acc);
        chk("rst_first_grant", 32'(acc), 32'(1));
        for (int i = 0; i < 6; i++) cycle(acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpcvt_arbiter.md
# fpcvt_arbiter

Round-robin scheduler that shares one 12-bit two's-complement to floating-point converter among `N_REQ` requesters. Each requester offers samples with a valid/ready handshake. The block arbitrates, registers the granted sample, converts it, and returns the sign, exponent, fraction and requester ID through a buffered valid/ready output port. It sits between the sample producers (switch/ADC front ends) and display/consumer logic.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  `N_REQ`: requester i has a sample.
- `req_data`  in  `12*N_REQ`: samples, two's complement; requester i occupies `[12i+11:12i]`.
- `req_ready`  out  `N_REQ`: one-hot or zero; requester i's sample is accepted on this edge.
- `out_valid`  out  1: result registered.
- `out_ready`  in  1: consumer takes the result.
- `out_id`  out  `ID_W`: source requester of the result.
- `out_s`  out  1: sign.
- `out_e`  out  3: exponent.
- `out_f`  out  4: fraction. Value is F·2^E.
- `sat_cnt`  out  8: present only with `FPCVT_ARB_SAT_CNT_EN` (see Configuration).

## Operation
**Arbitration**
- Round-robin pointer `rr`. Priority order is `rr`, `rr+1`, … modulo `N_REQ`.
- The grant goes to the first requester in that order with `req_valid` high.
- On each accept, `rr` becomes granted index + 1, wrapping to 0.

**Stage 1 (`s1`)**
- Holds `d_reg[11:0]`, `id_reg` and `s1_valid`.
- Loads when `s1` is empty or is advancing to the output on the same edge.

**Conversion** (combinational on `d_reg`)
- S = `d_reg[11]`. Magnitude = |D|; −2048 gives magnitude 2048.
- Let lz = leading zeros of the 12-bit magnitude. E = 8 − lz when lz is 1..8; E = 0 when lz ≥ 8.
- F = the 4 bits starting at the leading one. Round bit = the next lower bit.
- If the round bit is 1, F = F + 1.
- If F overflows, F = 1000 and E = E + 1.
- If E would exceed 7, clamp to E = 7, F = 1111.
- Saturation condition: magnitude ≥ 1984.

**Output register**
- Loads from `s1` when `s1_valid` is high and either `out_valid` is low or `out_ready` is high.
- Holds while `out_valid` is high and `out_ready` is low.

**Backpressure**
- `req_ready` is asserted only when `s1` can load.
- A stalled output therefore stalls `s1`, then the requesters.
- The grant is combinational from `req_valid`; a requester may drop `req_valid` without penalty before it is accepted.

## Timing
- **Reset:** `rr` = 0, `s1_valid` = 0, `out_valid` = 0, `out_id` = 0, `out_s`/`out_e`/`out_f` = 0, `sat_cnt` = 0. `req_ready` is 0 while `rst_n` is low.
- **Latency:** a sample accepted at edge k appears with `out_valid` high after edge k+1.
- **Throughput:** one result per cycle while `out_ready` stays high.
- **Full stall:** with `out_valid` high, `out_ready` low and `s1_valid` high, all `req_ready` are 0 and `rr` does not change.
- **Simultaneous drain and fill:** an output drain and an `s1` load on the same edge are allowed; no bubble is inserted.
- **Reset mid-operation:** in-flight samples are discarded and no partial results are produced.
- **Single requester:** a requester holding `req_valid` continuously with no competition is granted every cycle.
- **All requesters valid:** grants rotate 0,1,…,N−1,0.

## Configuration
- **`FPCVT_ARB_SAT_CNT_EN` defined:**
  - Adds port `sat_cnt[7:0]`.
  - Increments on each output-register load whose sample meets the saturation condition.
  - Saturates at 255; does not wrap.
  - Reset to 0.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Package `fpcvt_pkg`:**
  - `D_W` = 12, `E_W` = 3, `F_W` = 4, `SAT_MAG` = 1984.
  - Typedef `fp_res_t` {s, e, f}.
- **Sub-module `fpcvt_core`:**
  - Purely combinational `d[11:0]` → `fp_res_t` plus a `sat` flag.
  - Instantiated once, between `s1` and the output register.
- The arbiter, `rr` pointer, pipeline valids and counter live in `fpcvt_arbiter`.

## Test plan
- **Single requester, conversion:** req 0 sends 12'hE80 → after 2 edges `out_id` = 0, S = 1, E = 5, F = 1100. It then sends 12'h680 → S = 0, E = 7, F = 1101.
- **Rounding:** 12'h6C0 → E = 7, F = 1110. 12'h07C → E = 4, F = 1000 (F overflow). 12'h002 → E = 0, F = 0010.
- **Saturation:** 12'h800 → S = 1, E = 7, F = 1111, and `sat_cnt` 0→1 when `FPCVT_ARB_SAT_CNT_EN` is defined. Send 12'h7FF 300 times → `sat_cnt` stays at 255.
- **Fairness:** all 4 requesters continuously valid with `out_ready` = 1 → `out_id` sequence 0,1,2,3,0,1,… with one result per cycle.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles with traffic present → `out_valid` held with the result unchanged, all `req_ready` = 0 after `s1` fills, and no results lost or duplicated after release.
- **Reset mid-stream:** assert `rst_n` = 0 with `s1` and the output full → `out_valid` = 0 immediately. After release, req 0 has priority.
